// File: rtl/serial_tx_uart.sv
// ============================================================================
// serial_tx_uart : 8N1 LSB-first UART transmitter with optional input FIFO
//                  (FIFO enabled by defining SERIAL_TX_FIFO_EN).
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_tx_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_AW      = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DATA,
  input  logic       SEND,
  output logic       TX,
  output logic       READY
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      FIFO_AW < 1) begin : g_bad_param
    $error("serial_tx_uart: illegal parameter value");
  end

  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              start_w;
  logic [7:0]        start_byte;

`ifdef SERIAL_TX_FIFO_EN
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(2 ** FIFO_AW);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  logic [7:0]         mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               push_w, pop_w;

  assign READY      = (count_q != CNT_FULL);
  assign push_w     = SEND && READY;
  assign pop_w      = (state_q == ST_IDLE) && (count_q != '0);
  assign start_w    = pop_w;
  assign start_byte = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_w) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_w)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_w && !pop_w)      count_d = count_q + CNT_ONE;
    else if (pop_w && !push_w) count_d = count_q - CNT_ONE;
  end

  // Storage is not reset; flushing the pointers and count empties it.
  always_ff @(posedge CLK) begin
    if (push_w) mem_q[wr_ptr_q] <= DATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  assign READY      = (state_q == ST_IDLE);
  assign start_w    = SEND && READY;
  assign start_byte = DATA;
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (start_w) begin
          state_d = ST_START;
          shift_d = start_byte;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        // bit_q doubles as the stop-bit index here.
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
    endcase

    // Line level follows the next state so TX lines up with the state it belongs to.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign TX = tx_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_tx_uart.sv
// ============================================================================
// tb_serial_tx_uart : directed self-checking bench for serial_tx_uart
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_serial_tx_uart;

  logic       clk;
  logic       rst;
  logic [7:0] data1, data2;
  logic       send1, send2;
  logic       tx1, tx2;
  logic       ready1, ready2;
  int         checks;
  int         errors;
  int         cyc;

`ifdef SERIAL_TX_FIFO_EN
  serial_tx_uart #(.CLKS_PER_BIT(4), .STOP_BITS(1), .FIFO_AW(2)) u_dut (
`else
  serial_tx_uart #(.CLKS_PER_BIT(4), .STOP_BITS(1), .FIFO_AW(4)) u_dut (
`endif
    .CLK   (clk),
    .RESET (rst),
    .DATA  (data1),
    .SEND  (send1),
    .TX    (tx1),
    .READY (ready1)
  );

  serial_tx_uart #(.CLKS_PER_BIT(4), .STOP_BITS(2), .FIFO_AW(2)) u_dut2 (
    .CLK   (clk),
    .RESET (rst),
    .DATA  (data2),
    .SEND  (send2),
    .TX    (tx2),
    .READY (ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

`ifndef SERIAL_TX_FIFO_EN
  // Expected line level idx cycles after the accepting edge, 4 clocks per bit.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    int k;
    k = idx / 4;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic send_byte(input bit sel, input logic [7:0] b);
    @(negedge clk);
    if (sel) begin data2 = b; send2 = 1'b1; end
    else     begin data1 = b; send1 = 1'b1; end
    @(negedge clk);
    send1 = 1'b0;
    send2 = 1'b0;
  endtask

  // Starts at the first negedge after the accepting edge; inj >= 0 strobes 0xAA mid-frame.
  task automatic expect_frame(input bit sel, input logic [7:0] b, input int stops,
                              input int inj, input string tag);
    for (int i = 0; i < (9 + stops) * 4; i++) begin
      check({tag, "_tx"}, sel ? tx2 : tx1, frame_bit(b, i));
      if (i == 0 || i == inj) check({tag, "_busy"}, sel ? ready2 : ready1, 1'b0);
      if (!sel) begin
        if (i == inj) begin data1 = 8'hAA; send1 = 1'b1; end
        else send1 = 1'b0;
      end
      @(negedge clk);
    end
    send1 = 1'b0;
    check({tag, "_ready_end"}, sel ? ready2 : ready1, 1'b1);
    check({tag, "_tx_end"}, sel ? tx2 : tx1, 1'b1);
  endtask

  task automatic watch_idle(input string tag, input int n);
    int lows;
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (!tx1) lows++;
    end
    check(tag, lows, 0);
  endtask
`else
  int starts[5];

  // Decodes one frame on tx1 by mid-bit sampling; records the start cycle.
  task automatic rx_byte(input int slot, output logic [7:0] b);
    int waited;
    waited = 0;
    b = 8'h00;
    while (tx1 !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      check("rx_timeout", 1, 0);
      return;
    end
    starts[slot] = cyc;
    repeat (2) @(negedge clk);
    check("rx_start_mid", tx1, 1'b0);
    for (int j = 0; j < 8; j++) begin
      repeat (4) @(negedge clk);
      b[j] = tx1;
    end
    repeat (4) @(negedge clk);
    check("rx_stop_mid", tx1, 1'b1);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    data1  = 8'h00;
    data2  = 8'h00;
    send1  = 1'b0;
    send2  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx1, 1'b1);
    check("reset_ready", ready1, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_tx", tx1, 1'b1);
    check("post_reset_ready", ready1, 1'b1);

`ifndef SERIAL_TX_FIFO_EN
    // Single byte 0x1B
    send_byte(1'b0, 8'h1B);
    expect_frame(1'b0, 8'h1B, 1, -1, "single_1b");

    // Poll, strobe, poll: no duplicate frame
    check("gpu_poll_before", ready1, 1'b1);
    send_byte(1'b0, 8'h5B);
    check("gpu_poll_after", ready1, 1'b0);
    expect_frame(1'b0, 8'h5B, 1, -1, "gpu_5b");
    watch_idle("gpu_no_duplicate", 50);

    // SEND while busy is dropped
    send_byte(1'b0, 8'h3C);
    expect_frame(1'b0, 8'h3C, 1, 10, "busy_3c");
    watch_idle("busy_aa_dropped", 50);

    // Reset mid-frame at cycle 15 of a 0x00 frame
    send_byte(1'b0, 8'h00);
    repeat (14) @(negedge clk);
    check("midreset_tx_low", tx1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_tx", tx1, 1'b1);
    check("midreset_ready", ready1, 1'b1);
    watch_idle("midreset_abandoned", 10);
    send_byte(1'b0, 8'h41);
    expect_frame(1'b0, 8'h41, 1, -1, "after_reset_41");

    // Two stop bits, 0xFF
    send_byte(1'b1, 8'hFF);
    expect_frame(1'b1, 8'hFF, 2, -1, "stop2_ff");

    // Back-to-back: accept in the first idle cycle restarts immediately
    send_byte(1'b0, 8'h81);
    expect_frame(1'b0, 8'h81, 1, -1, "b2b_first");
    data1 = 8'h7E;
    send1 = 1'b1;
    @(negedge clk);
    send1 = 1'b0;
    expect_frame(1'b0, 8'h7E, 1, -1, "b2b_second");
`else
    begin
      logic [7:0] got;
      logic [7:0] exp_bytes [5];
      exp_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
      fork
        begin
          for (int i = 0; i < 6; i++) begin
            check($sformatf("fifo_ready_%0d", i), ready1, (i < 5) ? 1'b1 : 1'b0);
            data1 = 8'h31 + 8'(i);
            send1 = 1'b1;
            @(negedge clk);
          end
          send1 = 1'b0;
        end
        begin
          for (int k = 0; k < 5; k++) begin
            rx_byte(k, got);
            check($sformatf("fifo_byte_%0d", k), got, exp_bytes[k]);
          end
        end
      join
      for (int k = 1; k < 5; k++)
        check($sformatf("fifo_gap_%0d", k), starts[k] - starts[k-1], 41);
      repeat (50) @(negedge clk);
      check("fifo_no_sixth", tx1, 1'b1);
      check("fifo_ready_drained", ready1, 1'b1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
